// File: rtl/sig_ram_rd_arbiter_pkg.sv
// Shared types and constants for the signal-RAM read arbiter.
// Covers the RAM map, the FSM state type and the per-beat return tag.
package sig_ram_rd_arbiter_pkg;

  localparam int ADDR_W_DEF     = 9;
  localparam int DATA_W_DEF     = 32;
  localparam int SIG_DATA_WORDS = 320;
  localparam int SIG_HDR_BASE   = 500;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
    logic stale;
  } rd_tag_t;

endpackage

// File: rtl/sig_ram_rd_arbiter_tag_pipe.sv
// Return-path tag delay line that matches the RAM read latency.
// Also provides the per-requester rdata registers, each loaded only for its owner's beats.
module sig_rd_tag_pipe
  import sig_ram_rd_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_tag_t           tag_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] sig_out,
  output rd_tag_t           tag_out,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              any_valid
);

  rd_tag_t stg [RD_LATENCY];
  rd_tag_t pre;
  logic    pre_zero;

  // pre is the tag one stage before the output stage, aligned with sig_out
  generate
    if (RD_LATENCY == 1) begin : g_l1
      assign pre      = tag_in;
      assign pre_zero = zero_in;
    end else begin : g_ln
      logic [RD_LATENCY-2:0] zero_sr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          zero_sr <= '0;
        end else begin
          zero_sr[0] <= zero_in;
          for (int i = 1; i < RD_LATENCY - 1; i++) zero_sr[i] <= zero_sr[i-1];
        end
      end
      assign pre      = stg[RD_LATENCY-2];
      assign pre_zero = zero_sr[RD_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) stg[i] <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) stg[i] <= stg[i-1];
      if (pre.valid && !pre.owner) rdata0 <= pre_zero ? '0 : sig_out;
      if (pre.valid &&  pre.owner) rdata1 <= pre_zero ? '0 : sig_out;
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) any_valid = any_valid | stg[i].valid;
  end

  assign tag_out = stg[RD_LATENCY-1];

endmodule

// File: rtl/sig_ram_rd_arbiter.sv
// Round-robin burst arbiter for the signal RAM read port.
// Grants whole bursts, drives the read address, and routes tagged data back to the owner.
module sig_ram_rd_arbiter
  import sig_ram_rd_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk_clk,
  input  logic              rst_reset,
  output logic              sig_rdclk,
  output logic [ADDR_W-1:0] sig_rdaddress,
  input  logic [DATA_W-1:0] sig_out,
  input  logic              sig_ram_last,
  input  logic              rq0_req,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [ADDR_W-1:0] rq0_len,
  output logic              rq0_gnt,
  output logic [DATA_W-1:0] rq0_rdata,
  output logic              rq0_rvalid,
  output logic              rq0_rlast,
  output logic              rq0_stale,
  input  logic              rq1_req,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [ADDR_W-1:0] rq1_len,
  output logic              rq1_gnt,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic              rq1_rvalid,
  output logic              rq1_rlast,
  output logic              rq1_stale,
  output logic              busy,
  output logic              owner
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  arb_state_t        state, state_nxt;
  logic [ADDR_W-1:0] beats_left, beats_nxt, addr_nxt;
  logic              cur_owner, owner_nxt;
  logic              stale_acc, stale_nxt;
  logic              zero_pend, zero_nxt;
  logic              last_gnt, last_gnt_nxt;

  logic              window, grant, g_own, last_beat, any_valid;
  logic [ADDR_W-1:0] g_addr, g_len;
  rd_tag_t           tag_in, tag_out;

  assign sig_rdclk = clk_clk;

  always_comb begin
    last_beat = (state == ISSUE) && (beats_left == ONE);
    window    = !rst_reset && ((state == IDLE) || last_beat);
    // on a tie, the requester not granted last wins (last_gnt=1 means rq1)
    g_own     = rq1_req && (!rq0_req || !last_gnt);
    grant     = window && (rq0_req || rq1_req);
    g_addr    = g_own ? rq1_addr : rq0_addr;
    g_len     = g_own ? rq1_len  : rq0_len;
  end

  assign rq0_gnt = grant && !g_own;
  assign rq1_gnt = grant &&  g_own;

  always_comb begin
    state_nxt    = state;
    beats_nxt    = beats_left;
    addr_nxt     = sig_rdaddress;
    owner_nxt    = cur_owner;
    stale_nxt    = stale_acc;
    zero_nxt     = 1'b0;
    last_gnt_nxt = last_gnt;
    if (state == ISSUE) begin
      beats_nxt = beats_left - ONE;
      stale_nxt = stale_acc | sig_ram_last;
      if (beats_left == ONE) state_nxt = IDLE;
      else                   addr_nxt  = sig_rdaddress + ONE;
    end
    if (grant) begin
      last_gnt_nxt = g_own;
      owner_nxt    = g_own;
      beats_nxt    = g_len;
      stale_nxt    = sig_ram_last;
      zero_nxt     = (g_len == '0);
      if (g_len != '0) begin
        state_nxt = ISSUE;
        addr_nxt  = g_addr;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk_clk or posedge rst_reset) begin
    if (rst_reset) begin
      state         <= IDLE;
      beats_left    <= '0;
      sig_rdaddress <= '0;
      cur_owner     <= 1'b0;
      stale_acc     <= 1'b0;
      zero_pend     <= 1'b0;
      last_gnt      <= 1'b1;
    end else begin
      state         <= state_nxt;
      beats_left    <= beats_nxt;
      sig_rdaddress <= addr_nxt;
      cur_owner     <= owner_nxt;
      stale_acc     <= stale_nxt;
      zero_pend     <= zero_nxt;
      last_gnt      <= last_gnt_nxt;
    end
  end

  // a frame pulse in the same cycle as a new grant belongs to the new burst only
  always_comb begin
    tag_in.valid = (state == ISSUE) || zero_pend;
    tag_in.owner = cur_owner;
    tag_in.last  = last_beat || zero_pend;
    tag_in.stale = last_beat && (stale_acc || (sig_ram_last && !grant));
  end

  sig_rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY),
    .DATA_W     (DATA_W)
  ) u_tag_pipe (
    .clk       (clk_clk),
    .rst       (rst_reset),
    .tag_in    (tag_in),
    .zero_in   (zero_pend),
    .sig_out   (sig_out),
    .tag_out   (tag_out),
    .rdata0    (rq0_rdata),
    .rdata1    (rq1_rdata),
    .any_valid (any_valid)
  );

  assign rq0_rvalid = tag_out.valid && !tag_out.owner;
  assign rq1_rvalid = tag_out.valid &&  tag_out.owner;
  assign rq0_rlast  = rq0_rvalid && tag_out.last;
  assign rq1_rlast  = rq1_rvalid && tag_out.last;
  assign rq0_stale  = rq0_rlast && tag_out.stale;
  assign rq1_stale  = rq1_rlast && tag_out.stale;

  assign busy  = (state == ISSUE) || zero_pend || any_valid;
  assign owner = cur_owner;

endmodule

// File: tb/tb_sig_ram_rd_arbiter.sv
// Scoreboard bench for sig_ram_rd_arbiter with a registered RAM model (RD_LATENCY=2).
// Expected addresses and beats are stamped with the cycle they must appear in.
module tb_sig_ram_rd_arbiter;
  import sig_ram_rd_arbiter_pkg::*;

  localparam int RDL = 2;
  localparam int AW  = 9;
  localparam int DW  = 32;

  logic          clk_clk = 1'b0;
  logic          rst_reset;
  logic          sig_rdclk;
  logic [AW-1:0] sig_rdaddress;
  logic [DW-1:0] sig_out = '0;
  logic          sig_ram_last = 1'b0;
  logic          rq0_req = 1'b0, rq1_req = 1'b0;
  logic [AW-1:0] rq0_addr = '0, rq1_addr = '0, rq0_len = '0, rq1_len = '0;
  logic          rq0_gnt, rq1_gnt;
  logic [DW-1:0] rq0_rdata, rq1_rdata;
  logic          rq0_rvalid, rq1_rvalid, rq0_rlast, rq1_rlast, rq0_stale, rq1_stale;
  logic          busy, owner;

  sig_ram_rd_arbiter #(.RD_LATENCY(RDL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_clk(clk_clk), .rst_reset(rst_reset), .sig_rdclk(sig_rdclk),
    .sig_rdaddress(sig_rdaddress), .sig_out(sig_out), .sig_ram_last(sig_ram_last),
    .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_len(rq0_len), .rq0_gnt(rq0_gnt),
    .rq0_rdata(rq0_rdata), .rq0_rvalid(rq0_rvalid), .rq0_rlast(rq0_rlast), .rq0_stale(rq0_stale),
    .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_len(rq1_len), .rq1_gnt(rq1_gnt),
    .rq1_rdata(rq1_rdata), .rq1_rvalid(rq1_rvalid), .rq1_rlast(rq1_rlast), .rq1_stale(rq1_stale),
    .busy(busy), .owner(owner)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    int            cyc;
    logic          own;
    logic [DW-1:0] d;
    logic          lst;
    logic          stl;
  } beat_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
  } adr_t;

  beat_t dq[$];
  adr_t  aq[$];
  int    cyc = 0;
  int    pulse_cyc = -100;
  int    n_chk = 0;
  int    n_err = 0;

  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    return {7'h5A, a, 7'h13, ~a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // registered RAM: word for the address shown in cycle k is on sig_out in cycle k+1
  always @(posedge clk_clk) sig_out <= ram_f(sig_rdaddress);

  initial forever begin
    @(posedge clk_clk);
    cyc++;
    #1;
    sig_ram_last = (cyc == pulse_cyc);
  end

  // Called just after a posedge; returns just after a posedge with req dropped.
  task automatic burst(input int n, input logic [AW-1:0] a, input logic [AW-1:0] l,
                       input int poff, output int tg);
    int            k;
    logic          st;
    logic [AW-1:0] ai;
    if (n == 0) begin rq0_req = 1'b1; rq0_addr = a; rq0_len = l; end
    else        begin rq1_req = 1'b1; rq1_addr = a; rq1_len = l; end
    tg = -1;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk_clk);
      if ((n == 0 && rq0_gnt) || (n == 1 && rq1_gnt)) begin
        tg = cyc;
        break;
      end
    end
    if (tg < 0) begin
      check_eq("gnt_timeout", 64'(n), 64'hFF);
    end else begin
      st = (l != '0) && (poff >= 1) && (poff <= int'(l));
      if (poff >= 1) pulse_cyc = tg + poff;
      if (l == '0) begin
        dq.push_back('{tg + 1 + RDL, n[0], '0, 1'b1, 1'b0});
      end else begin
        for (int i = 0; i < int'(l); i++) begin
          ai = a + AW'(i);
          aq.push_back('{tg + 1 + i, ai});
          dq.push_back('{tg + 1 + RDL + i, n[0], ram_f(ai), (i == int'(l) - 1), (i == int'(l) - 1) && st});
        end
      end
    end
    @(posedge clk_clk);
    #1;
    if (n == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((dq.size() != 0 || aq.size() != 0) && k < 3000) begin
      @(posedge clk_clk);
      k++;
    end
    @(posedge clk_clk);
    #1;
    check_eq("drain", 64'(dq.size() + aq.size()), 64'd0);
    check_eq("busy_idle", busy, 1'b0);
  endtask

  initial begin : monitor
    beat_t e;
    adr_t  ea;
    forever begin
      @(negedge clk_clk);
      if (!rst_reset) begin
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
          ea = aq.pop_front();
          check_eq("rdaddress", sig_rdaddress, ea.a);
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          e = dq.pop_front();
          if (!e.own) begin
            check_eq("rq0_flags", {rq0_rvalid, rq0_rlast, rq0_stale}, {1'b1, e.lst, e.stl});
            check_eq("rq0_rdata", rq0_rdata, e.d);
            check_eq("rq1_quiet", {rq1_rvalid, rq1_rlast, rq1_stale}, 3'b000);
          end else begin
            check_eq("rq1_flags", {rq1_rvalid, rq1_rlast, rq1_stale}, {1'b1, e.lst, e.stl});
            check_eq("rq1_rdata", rq1_rdata, e.d);
            check_eq("rq0_quiet", {rq0_rvalid, rq0_rlast, rq0_stale}, 3'b000);
          end
        end else begin
          check_eq("no_beat", {rq0_rvalid, rq1_rvalid}, 2'b00);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0, t1;
    rst_reset = 1'b1;
    #2;
    check_eq("reset_state",
             {sig_rdaddress, busy, owner, rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid,
              rq0_rlast, rq1_rlast, rq0_stale, rq1_stale}, '0);
    check_eq("reset_rdata", {rq0_rdata, rq1_rdata}, '0);
    #10 rst_reset = 1'b0;
    while (cyc != 10) begin @(posedge clk_clk); #1; end

    // full data region to rq0
    burst(0, '0, AW'(SIG_DATA_WORDS), -1, t0);
    check_eq("t1_gnt_cycle", 64'(t0), 64'd10);
    check_eq("t1_busy_owner", {busy, owner}, 2'b10);
    wait_drain();

    // fresh priority after reset: rq0 first, rq1 in rq0's last issue cycle
    @(posedge clk_clk); #3 rst_reset = 1'b1;
    @(posedge clk_clk); #3 rst_reset = 1'b0;
    @(posedge clk_clk); #1;
    fork
      burst(0, 9'd100, 9'd8, -1, t0);
      burst(1, 9'd200, 9'd5, -1, t1);
    join
    check_eq("pair1_order", 64'(t1 - t0), 64'd8);
    wait_drain();
    fork
      burst(0, 9'd300, 9'd6, -1, t0);
      burst(1, 9'd310, 9'd4, -1, t1);
    join
    check_eq("pair2_order", 64'(t1 - t0), 64'd6);
    wait_drain();

    // header read and address wrap
    burst(1, AW'(SIG_HDR_BASE), 9'd3, -1, t1);
    check_eq("hdr_owner", owner, 1'b1);
    wait_drain();
    burst(0, 9'd510, 9'd4, -1, t0);
    wait_drain();
    check_eq("rq1_rdata_hold", rq1_rdata, ram_f(9'd502));
    check_eq("rq0_rdata_wrap", rq0_rdata, ram_f(9'd1));

    // frame update: mid-burst, on last issue cycle, one cycle after
    burst(1, '0, AW'(SIG_DATA_WORDS), 100, t1);
    wait_drain();
    burst(0, 9'd40, 9'd10, 10, t0);
    wait_drain();
    burst(0, 9'd20, 9'd10, 11, t0);
    wait_drain();

    // zero-length burst
    burst(0, 9'd77, 9'd0, -1, t0);
    wait_drain();
    check_eq("zero_rdata", rq0_rdata, 32'h0);

    // reset in the middle of a long burst
    burst(0, '0, AW'(SIG_DATA_WORDS), -1, t0);
    repeat (50) @(posedge clk_clk);
    #3 rst_reset = 1'b1;
    #1;
    check_eq("midrst_state",
             {sig_rdaddress, busy, owner, rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid,
              rq0_rlast, rq1_rlast, rq0_stale, rq1_stale}, '0);
    check_eq("midrst_rdata", {rq0_rdata, rq1_rdata}, '0);
    aq.delete();
    dq.delete();
    @(posedge clk_clk); #3 rst_reset = 1'b0;
    repeat (10) @(posedge clk_clk);
    #1;
    check_eq("postrst_busy", busy, 1'b0);
    fork
      burst(1, 9'd60, 9'd3, -1, t1);
      burst(0, 9'd50, 9'd5, -1, t0);
    join
    check_eq("postrst_order", 64'(t1 - t0), 64'd5);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
